// File: rtl/dmem_port_arbiter.sv
// Serialises 64-bit fetch/data accesses onto one byte-wide synchronous RAM, big-endian, 8 beats.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise data always beats fetch.
module dmem_port_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [63:0]   i_addr,
  output logic          i_ack,
  output logic          i_err,
  output logic [63:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [63:0]   d_addr,
  input  logic [63:0]   d_wdata,
  output logic          d_ack,
  output logic          d_err,
  output logic [63:0]   d_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic          busy
);

  localparam logic [63:0] MaxAddr = 64'(MEM_BYTES - 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_LAST = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    beat_q, beat_d;
  logic [AW-1:0] base_q, base_d;
  logic          we_q, we_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          owner_q, owner_d;
  logic [63:0]   buf_q, buf_d;
  logic          i_ack_q, i_ack_d;
  logic          i_err_q, i_err_d;
  logic [63:0]   i_rdata_q, i_rdata_d;
  logic          d_ack_q, d_ack_d;
  logic          d_err_q, d_err_d;
  logic [63:0]   d_rdata_q, d_rdata_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [7:0]    ram_wdata_q, ram_wdata_d;
  logic          busy_q, busy_d;

  logic          grant_d_s;
  logic [63:0]   req_addr_s;
  logic          req_we_s;
  logic [2:0]    next_beat_s;
  logic [63:0]   read_word_s;

`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;
`endif

  // Winner selection and the latched-request view of the winner.
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    grant_d_s = d_req && (!i_req || !last_q);
`else
    grant_d_s = d_req;
`endif
    req_addr_s  = grant_d_s ? d_addr : i_addr;
    req_we_s    = grant_d_s & d_we;
    next_beat_s = beat_q + 3'd1;
    read_word_s = {buf_q[55:0], ram_rdata};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    base_d      = base_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    owner_d     = owner_q;
    buf_d       = buf_q;
    i_ack_d     = 1'b0;
    i_err_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
`ifdef DMEM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          owner_d = grant_d_s;
          we_d    = req_we_s;
          wdata_d = req_we_s ? d_wdata : 64'd0;
`ifdef DMEM_ARB_RR_EN
          last_d  = grant_d_s;
`endif
          if (req_addr_s > MaxAddr) begin
            state_d = S_ACK;
            if (grant_d_s) begin
              d_ack_d   = 1'b1;
              d_err_d   = 1'b1;
              d_rdata_d = 64'd0;
            end else begin
              i_ack_d   = 1'b1;
              i_err_d   = 1'b1;
              i_rdata_d = 64'd0;
            end
          end else begin
            state_d    = S_XFER;
            beat_d     = 3'd0;
            base_d     = req_addr_s[AW-1:0];
            buf_d      = 64'd0;
            ram_addr_d = req_addr_s[AW-1:0];
            ram_we_d   = req_we_s;
            if (req_we_s) begin
              ram_wdata_d = d_wdata[63:56];
            end else begin
              ram_wdata_d = ram_wdata_q;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_XFER: begin
        // RAM read data lags the address by one beat, so beat k sees byte k-1.
        if (!we_q && (beat_q != 3'd0)) begin
          buf_d = read_word_s;
        end else begin
          buf_d = buf_q;
        end
        if (beat_q == 3'd7) begin
          if (we_q) begin
            state_d = S_ACK;
            if (owner_q) begin
              d_ack_d   = 1'b1;
              d_rdata_d = 64'd0;
            end else begin
              i_ack_d   = 1'b1;
              i_rdata_d = 64'd0;
            end
          end else begin
            state_d = S_LAST;
          end
        end else begin
          beat_d     = next_beat_s;
          ram_addr_d = base_q + AW'(next_beat_s);
          ram_we_d   = we_q;
          wdata_d    = {wdata_q[55:0], 8'd0};
          if (we_q) begin
            ram_wdata_d = wdata_q[55:48];
          end else begin
            ram_wdata_d = ram_wdata_q;
          end
        end
      end
      S_LAST: begin
        state_d = S_ACK;
        if (owner_q) begin
          d_ack_d   = 1'b1;
          d_rdata_d = read_word_s;
        end else begin
          i_ack_d   = 1'b1;
          i_rdata_d = read_word_s;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      beat_q      <= 3'd0;
      base_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 64'd0;
      owner_q     <= 1'b0;
      buf_q       <= 64'd0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= 64'd0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= 64'd0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= 8'd0;
      busy_q      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      buf_q       <= buf_d;
      i_ack_q     <= i_ack_d;
      i_err_q     <= i_err_d;
      i_rdata_q   <= i_rdata_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
`ifdef DMEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;

endmodule
